// File: rtl/psum_writeback_pkg.sv
// Shared types and defaults for the partial-sum writeback stage.
// Contents:
//   - default parameter values for the PE-array drain path
//   - FSM state type
//   - helper for sizing column-index signals
package psum_writeback_pkg;

  localparam int unsigned PwbNumCols   = 8;
  localparam int unsigned PwbWordWidth = 128;
  localparam int unsigned PwbAddrWidth = 16;
  localparam int unsigned PwbFifoDepth = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } pwb_state_e;

  // Width of an index into n items; never returns zero.
  function automatic int unsigned pwb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_writeback_sync_fifo.sv
// Show-ahead synchronous FIFO used to serialise captured column words.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (clears pointers)
//   clr_i         synchronous flush of all entries
//   push_i        write wdata_i; honoured when not full, or when full and popping
//   wdata_i       write data
//   pop_i         drop the head entry; ignored when empty
//   rdata_o       head entry (valid while empty_o is low)
//   full_o        no free entry
//   empty_o       no stored entry
module psum_writeback_sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = pop_i & ~empty_o;
  assign w_wr    = push_i & (~full_o | w_rd);
  assign rdata_o = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW + 1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/psum_writeback.sv
// Drain stage behind the PE-array columns. Each column delivers one finished
// word as a single-cycle pulse; words are held per column, serialised through
// a FIFO in lowest-column-first order and written to the global buffer at
// base + running count, one per accepted cycle.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i                  begin a job (ignored while busy_o)
//   base_addr_i, num_words_i job parameters, sampled on start_i
//   col_we_i, col_word_i     per-column word pulse / data (column k at [k*W +: W])
//   gbuf_ready_i             global buffer accepts a write
//   gbuf_we_o, gbuf_addr_o, gbuf_wdata_o  write port
//   busy_o                   job in progress
//   done_o                   single-cycle completion pulse
//   ovf_o                    sticky: a word was dropped because its column was still held
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int unsigned NUM_COLS   = PwbNumCols,
  parameter int unsigned WORD_WIDTH = PwbWordWidth,
  parameter int unsigned ADDR_WIDTH = PwbAddrWidth,
  parameter int unsigned FIFO_DEPTH = PwbFifoDepth
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [ADDR_WIDTH-1:0]          base_addr_i,
  input  logic [ADDR_WIDTH-1:0]          num_words_i,
  input  logic [NUM_COLS-1:0]            col_we_i,
  input  logic [NUM_COLS*WORD_WIDTH-1:0] col_word_i,
  input  logic                           gbuf_ready_i,
  output logic                           gbuf_we_o,
  output logic [ADDR_WIDTH-1:0]          gbuf_addr_o,
  output logic [WORD_WIDTH-1:0]          gbuf_wdata_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           ovf_o
);

  localparam int unsigned IdxW = pwb_idx_w(NUM_COLS);

  pwb_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_num;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_done;
  logic                  r_ovf;
  logic [NUM_COLS-1:0]   r_pend;
  logic [WORD_WIDTH-1:0] r_hold [NUM_COLS];

  logic                  w_run;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_push;
  logic                  w_any;
  logic [IdxW-1:0]       w_sel_idx;
  logic [NUM_COLS-1:0]   w_clr;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [WORD_WIDTH-1:0] w_head;

  assign w_run        = (r_state == StRun);
  assign gbuf_we_o    = w_run & ~w_fifo_empty;
  assign gbuf_addr_o  = r_base + r_cnt;
  // Head is gated so the data bus reads zero rather than stale RAM when idle.
  assign gbuf_wdata_o = w_fifo_empty ? '0 : w_head;
  assign busy_o       = w_run;
  assign done_o       = r_done;
  assign ovf_o        = r_ovf;

  assign w_pop  = gbuf_we_o & gbuf_ready_i;
  assign w_last = w_pop & (r_cnt == r_num - ADDR_WIDTH'(1));

  // Lowest pending column wins; scanning downwards lets the lowest overwrite.
  always_comb begin
    w_any     = 1'b0;
    w_sel_idx = '0;
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_any     = 1'b1;
        w_sel_idx = IdxW'(k);
      end
    end
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push = w_any & (~w_fifo_full | w_pop) & ~w_last;

  always_comb begin
    w_clr = '0;
    if (w_push) w_clr[w_sel_idx] = 1'b1;
  end

  // Capture: a column that fires while its previous word is still held (and
  // not leaving this cycle) loses the new word. The final write of a job
  // flushes anything left over so it cannot leak into the next job.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < NUM_COLS; k++) r_hold[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_COLS; k++) begin
        if (w_last) begin
          r_pend[k] <= 1'b0;
        end else if (w_run && col_we_i[k]) begin
          if (r_pend[k] && !w_clr[k]) begin
            r_ovf <= 1'b1;
          end else begin
            r_hold[k] <= col_word_i[k*WORD_WIDTH +: WORD_WIDTH];
            r_pend[k] <= 1'b1;
          end
        end else if (w_clr[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_base <= base_addr_i;
            r_num  <= num_words_i;
            r_cnt  <= '0;
            // An empty job completes immediately without entering RUN.
            if (num_words_i == '0) r_done  <= 1'b1;
            else                   r_state <= StRun;
          end
        end
        StRun: begin
          if (w_pop) begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
            if (w_last) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  psum_writeback_sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_last),
    .push_i  (w_push),
    .wdata_i (r_hold[w_sel_idx]),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

endmodule
